// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MUSA memory-access stage: dmem req/ack transactions and registered write-back.
// Optional abort-on-timeout logic is built when MEM_TIMEOUT_EN is defined.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        mem_error
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0] state;
  logic [4:0] lat_rd;
  logic       lat_rw;
  logic       mem_op;
  logic       timeout_hit;

  assign mem_op = ex_mem_read | ex_mem_write;
  assign stall  = (state == S_ACCESS) || (ex_valid && mem_op);

`ifdef MEM_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        err_q;

  // Abort lands on the TIMEOUT_CYCLES-th ACCESS edge without ack.
  assign timeout_hit = (to_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign mem_error   = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= 16'd0;
      err_q  <= 1'b0;
    end else if (state == S_IDLE) begin
      to_cnt <= 16'd0;
    end else if (!dmem_ack) begin
      to_cnt <= to_cnt + 16'd1;
      if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign mem_error      = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'd0;
      dmem_wdata   <= 32'd0;
      lat_rd       <= 5'd0;
      lat_rw       <= 1'b0;
      wb_valid     <= 1'b0;
      wb_data      <= 32'd0;
      wb_rd        <= 5'd0;
      wb_reg_write <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (state == S_IDLE) begin
        if (ex_valid && mem_op) begin
          // A bundle flagged both read and write is issued as a store.
          dmem_req   <= 1'b1;
          dmem_we    <= ex_mem_write;
          dmem_addr  <= ex_result;
          dmem_wdata <= ex_store_data;
          lat_rd     <= ex_rd;
          lat_rw     <= ex_reg_write;
          state      <= S_ACCESS;
        end else if (ex_valid) begin
          wb_valid     <= 1'b1;
          wb_data      <= ex_result;
          wb_rd        <= ex_rd;
          wb_reg_write <= ex_reg_write && (ex_rd != 5'd0);
        end
      end else begin
        if (dmem_ack) begin
          dmem_req     <= 1'b0;
          wb_valid     <= 1'b1;
          wb_rd        <= lat_rd;
          wb_data      <= dmem_we ? dmem_addr : dmem_rdata;
          wb_reg_write <= !dmem_we && lat_rw && (lat_rd != 5'd0);
          state        <= S_IDLE;
        end else if (timeout_hit) begin
          dmem_req     <= 1'b0;
          wb_valid     <= 1'b1;
          wb_rd        <= lat_rd;
          wb_data      <= 32'd0;
          wb_reg_write <= 1'b0;
          state        <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a transaction-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_result = '0;
  logic [31:0] ex_store_data = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_write = 1'b0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        mem_error;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_wb_data = '0;
  logic        exp_err = 1'b0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One non-retiring cycle with ack noise; ack must be ignored in IDLE.
  task automatic idle_cycle();
    ex_valid = 1'b0;
    dmem_ack = 1'($urandom_range(0, 1));
    #1 check("idle_stall", stall, 0);
    @(negedge clk);
    dmem_ack = 1'b0;
    check("idle_wb_valid", wb_valid, 0);
    check("idle_req", dmem_req, 0);
    check("idle_wb_hold", wb_data, last_wb_data);
    check("idle_err", mem_error, exp_err);
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 load+store (treated as store). Starts and ends at a negedge (+1).
  task automatic run_bundle(input int kind, input logic [31:0] res, input logic [31:0] sdata,
                            input logic [4:0] rd, input logic rw, input int delay,
                            input logic [31:0] rdata);
    logic        is_mem;
    logic        is_store;
    logic [31:0] exp_data;
    logic        exp_rw;
    is_mem   = (kind != 0);
    is_store = (kind >= 2);
    ex_valid = 1'b1;
    ex_result = res;
    ex_store_data = sdata;
    ex_mem_read = (kind == 1) || (kind == 3);
    ex_mem_write = is_store;
    ex_rd = rd;
    ex_reg_write = rw;
    dmem_ack = 1'b0;
    #1 check("accept_stall", stall, 32'(is_mem));
    exp_data = !is_mem ? res : (is_store ? res : rdata);
    exp_rw   = !is_store && rw && (rd != 5'd0);
    @(negedge clk);
    if (!is_mem) begin
      check("alu_wb_valid", wb_valid, 1);
      check("alu_wb_data", wb_data, exp_data);
      check("alu_wb_rd", wb_rd, 32'(rd));
      check("alu_wb_rw", wb_reg_write, 32'(exp_rw));
      check("alu_req", dmem_req, 0);
    end else begin
      check("mem_req", dmem_req, 1);
      check("mem_we", dmem_we, 32'(is_store));
      check("mem_addr", dmem_addr, res);
      if (is_store) check("mem_wdata", dmem_wdata, sdata);
      check("mem_wb_quiet", wb_valid, 0);
      for (int i = 0; i < delay; i++) begin
        #1 check("wait_stall", stall, 1);
        @(negedge clk);
        check("wait_req", dmem_req, 1);
        check("wait_addr", dmem_addr, res);
        check("wait_wb_quiet", wb_valid, 0);
      end
      dmem_ack = 1'b1;
      dmem_rdata = rdata;
      @(negedge clk);
      dmem_ack = 1'b0;
      ex_valid = 1'b0;
      check("done_wb_valid", wb_valid, 1);
      check("done_req", dmem_req, 0);
      check("done_wb_data", wb_data, exp_data);
      check("done_wb_rw", wb_reg_write, 32'(exp_rw));
      if (!is_store) check("done_wb_rd", wb_rd, 32'(rd));
      #1 check("done_stall", stall, 0);
    end
    check("bundle_err", mem_error, exp_err);
    last_wb_data = exp_data;
  endtask

  initial begin
    @(negedge clk);
    check("rst_req", dmem_req, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_err", mem_error, 0);
    check("rst_stall", stall, 0);
    reset = 1'b1;
    @(negedge clk);

    run_bundle(0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0, 32'h0);
    run_bundle(1, 32'h0000_0040, 32'h0, 5'd7, 1'b1, 2, 32'hDEAD_BEEF);
    run_bundle(3, 32'h0000_0080, 32'h55AA_55AA, 5'd9, 1'b1, 1, 32'h1111_2222);
    run_bundle(1, 32'h0000_0100, 32'h0, 5'd0, 1'b1, 0, 32'hCAFE_F00D);
    idle_cycle();

    // Asynchronous reset in the middle of an outstanding load.
    run_bundle(0, 32'h0BAD_0BAD, 32'h0, 5'd3, 1'b1, 0, 32'h0);
    ex_valid = 1'b1; ex_result = 32'h0000_0200; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_rd = 5'd4; ex_reg_write = 1'b1;
    @(negedge clk);
    check("pre_rst_req", dmem_req, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_req", dmem_req, 0);
    check("arst_we", dmem_we, 0);
    check("arst_addr", dmem_addr, 0);
    check("arst_wdata", dmem_wdata, 0);
    check("arst_wb_valid", wb_valid, 0);
    check("arst_wb_data", wb_data, 0);
    check("arst_wb_rd", wb_rd, 0);
    check("arst_wb_rw", wb_reg_write, 0);
    check("arst_err", mem_error, 0);
    ex_valid = 1'b0;
    #1 check("arst_stall", stall, 0);
    @(negedge clk);
    reset = 1'b1;
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("late_ack_wb", wb_valid, 0);
    check("late_ack_req", dmem_req, 0);
    last_wb_data = 32'h0;

    for (int n = 0; n < 80; n++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_bundle(int'($urandom_range(0, 3)), $urandom, $urandom, rd,
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

`ifdef MEM_TIMEOUT_EN
    ex_valid = 1'b1; ex_result = 32'h0000_0300; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_rd = 5'd6; ex_reg_write = 1'b1; dmem_ack = 1'b0;
    @(negedge clk);
    check("to_req", dmem_req, 1);
    repeat (3) begin
      @(negedge clk);
      check("to_wait_req", dmem_req, 1);
      check("to_wait_wb", wb_valid, 0);
      check("to_wait_err", mem_error, 0);
    end
    @(negedge clk);
    ex_valid = 1'b0;
    check("to_wb_valid", wb_valid, 1);
    check("to_wb_data", wb_data, 0);
    check("to_wb_rw", wb_reg_write, 0);
    check("to_req_drop", dmem_req, 0);
    check("to_err", mem_error, 1);
    #1 check("to_stall", stall, 0);
    exp_err = 1'b1;
    last_wb_data = 32'h0;
    run_bundle(0, 32'h0000_00AB, 32'h0, 5'd2, 1'b1, 0, 32'h0);
    run_bundle(1, 32'h0000_0044, 32'h0, 5'd8, 1'b1, 1, 32'h1234_5678);
    idle_cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
